alu_multicycle: RTL
===================

ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; legal values 8..64.
REQ-002 Localparam SHW = $clog2(WIDTH), shift-amount width; CW = $clog2(WIDTH+1), iteration-counter width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  operand/opcode presented.
REQ-006 in_ready  output  1  block can accept an operation.
REQ-007 A  input  WIDTH  first operand.
REQ-008 B  input  WIDTH  second operand / shift amount.
REQ-009 Ctr  input  4  opcode from shared package.
REQ-010 out_valid  output  1  Out holds a completed result.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 Out  output  WIDTH  registered result.

Function
REQ-013 Opcodes: ADD=0, SUB=1, SLL=2, SRL=3, SRA=4, AND=5, OR=6, XOR=7, MUL=8 (low WIDTH bits), MULHU=9 (high WIDTH bits, unsigned), DIVU=10, REMU=11; 12..15 undefined.
REQ-014 FSM states IDLE, BUSY, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-015 Accept = in_valid && in_ready; A, B, Ctr captured into internal registers on accept; inputs ignored otherwise.
REQ-016 Codes 0..7 and undefined codes: IDLE -> DONE on accept; Out valid in the next cycle (latency 1).
REQ-017 Shifts use B[SHW-1:0] only; SRA sign-fills from A[WIDTH-1]; arithmetic wraps modulo 2^WIDTH.
REQ-018 Undefined codes produce Out = 0.
REQ-019 Codes 8..11: IDLE -> BUSY on accept; exactly WIDTH BUSY cycles (one bit per cycle, shift-add multiply, restoring divide); BUSY -> DONE after the last iteration; out_valid asserted WIDTH+1 cycles after accept.
REQ-020 Multiply keeps a 2*WIDTH-bit product; MUL returns bits [WIDTH-1:0], MULHU bits [2*WIDTH-1:WIDTH].
REQ-021 DIVU by zero: Out = all-ones; REMU by zero: Out = A; same WIDTH-cycle latency as a nonzero divisor.
REQ-022 DONE: Out and out_valid held stable while out_ready=0; on out_ready=1 transition to IDLE next cycle.
REQ-023 No accept in DONE or BUSY; back-to-back throughput for single-cycle ops is one result per 2 cycles.
REQ-024 Out changes only on transition into DONE; Out retains the last result in IDLE and BUSY.
REQ-025 Iteration counter counts WIDTH down to 0 in BUSY; no wrap beyond 0.

Reset
REQ-026 rst_n low asynchronously forces state IDLE, Out=0, out_valid=0, counter=0, operand/product/quotient registers = 0.
REQ-027 in_ready=1 in the first cycle after rst_n deasserts.
REQ-028 Reset during BUSY or DONE discards the operation; no result is ever presented for it.

Structure
REQ-029 Opcode constants (4-bit) and the FSM state enum reside in the shared ALU package, replacing the per-file opcode macros.
REQ-030 The iterative multiply/divide datapath is one sub-module, alu_muldiv_iter (start, op, operands, done, result); the single-cycle ops stay inline.

Verification (WIDTH=32 unless stated)
REQ-031 ADD A=0xFFFFFFFF B=1 -> out_valid 1 cycle after accept, Out=0x00000000.
REQ-032 MUL and MULHU A=B=0xFFFFFFFF -> Out=0x00000001 and 0xFFFFFFFE respectively, out_valid exactly 33 cycles after accept, in_ready=0 throughout.
REQ-033 DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
REQ-034 SRA A=0x80000000 B=0x00000024 (amount 4) -> 0xF8000000; out_ready held low 3 cycles -> Out and out_valid stable, IDLE one cycle after out_ready rises.
REQ-035 rst_n pulsed low at BUSY cycle 10 of a DIVU -> out_valid stays 0, in_ready=1 first cycle after release, next ADD 2+3 -> 5.
REQ-036 WIDTH=8: MULHU 0xFF*0xFF -> 0xFE after 9 cycles; Ctr=14 -> Out=0 after 1 cycle.

Source files
------------

// File: rtl/alu_multicycle_pkg.sv
// Shared ALU definitions: opcodes, FSM states and helpers.
// Imported by the top and the iterative mul/div unit.
package alu_multicycle_pkg;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_SLL   = 4'd2;
  localparam logic [3:0] OP_SRL   = 4'd3;
  localparam logic [3:0] OP_SRA   = 4'd4;
  localparam logic [3:0] OP_AND   = 4'd5;
  localparam logic [3:0] OP_OR    = 4'd6;
  localparam logic [3:0] OP_XOR   = 4'd7;
  localparam logic [3:0] OP_MUL   = 4'd8;
  localparam logic [3:0] OP_MULHU = 4'd9;
  localparam logic [3:0] OP_DIVU  = 4'd10;
  localparam logic [3:0] OP_REMU  = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_e;

  function automatic logic is_muldiv(input logic [3:0] op);
    return op[3:2] == 2'b10;
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unit: shift-add multiply and restoring divide,
// one bit per cycle for WIDTH cycles after start.
module alu_muldiv_iter
  import alu_multicycle_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]      cnt_q, cnt_d;
  logic [3:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   rem_q, rem_d;

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    prod_d  = prod_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    done    = 1'b0;
    sum     = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
            + {1'b0, (prod_q[0] ? a_q : '0)};
    shifted = {rem_q, quo_q[WIDTH-1]};
    diff    = shifted - {1'b0, b_q};
    if (start) begin
      op_d   = op;
      a_d    = a;
      b_d    = b;
      prod_d = {{WIDTH{1'b0}}, b};
      quo_d  = a;
      rem_d  = '0;
      cnt_d  = CW'(WIDTH);
    end else if (cnt_q != '0) begin
      cnt_d  = cnt_q - 1'b1;
      prod_d = {sum, prod_q[WIDTH-1:1]};
      // borrow out of the trial subtract means restore
      if (!diff[WIDTH]) begin
        rem_d = diff[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_d = shifted[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b0};
      end
      done = (cnt_q == CW'(1));
    end
  end

  always_comb begin
    result = '0;
    unique case (1'b1)
      (op_q == OP_MUL):   result = prod_d[WIDTH-1:0];
      (op_q == OP_MULHU): result = prod_d[2*WIDTH-1:WIDTH];
      (op_q == OP_DIVU):  result = quo_d;
      default:            result = rem_d;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      prod_q <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      op_q   <= op_d;
      a_q    <= a_d;
      b_q    <= b_d;
      prod_q <= prod_d;
      quo_q  <= quo_d;
      rem_q  <= rem_d;
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// Multicycle ALU: single-cycle logic/arith ops inline,
// mul/div delegated to the iterative unit.
module alu_multicycle
  import alu_multicycle_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       Ctr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Out
);

  localparam int SHW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] alu_res;
  logic [SHW-1:0]   shamt;
  logic             accept;
  logic             md_start;
  logic             md_done;
  logic [WIDTH-1:0] md_result;

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign accept    = in_valid && in_ready;
  assign shamt     = B[SHW-1:0];
  assign Out       = out_q;

  always_comb begin
    alu_res = '0;
    unique case (1'b1)
      (Ctr == OP_ADD): alu_res = A + B;
      (Ctr == OP_SUB): alu_res = A - B;
      (Ctr == OP_SLL): alu_res = A << shamt;
      (Ctr == OP_SRL): alu_res = A >> shamt;
      (Ctr == OP_SRA): alu_res = $signed(A) >>> shamt;
      (Ctr == OP_AND): alu_res = A & B;
      (Ctr == OP_OR):  alu_res = A | B;
      (Ctr == OP_XOR): alu_res = A ^ B;
      default:         alu_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    out_d    = out_q;
    md_start = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_muldiv(Ctr)) begin
            md_start = 1'b1;
            state_d  = ST_BUSY;
          end else begin
            out_d   = alu_res;
            state_d = ST_DONE;
          end
        end
      end
      ST_BUSY: begin
        if (md_done) begin
          out_d   = md_result;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
    end
  end

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (md_start),
    .op     (Ctr),
    .a      (A),
    .b      (B),
    .done   (md_done),
    .result (md_result)
  );

endmodule
